// File: rtl/gpio_bank_fpga.sv
// GPIO bank: tristate pads, write-mode output register, synchronised and
// debounced inputs with edge events and sticky per-pin interrupts.
module gpio_bank_fpga #(
    parameter int PINS_COUNT      = 17,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  CLK50,
    input  logic                  RST_N,
    inout  wire  [PINS_COUNT-1:0] io_pins,
    input  logic [PINS_COUNT-1:0] dir,
    input  logic                  wr_en,
    input  logic [1:0]            wr_mode,
    input  logic [PINS_COUNT-1:0] wr_data,
    output logic [PINS_COUNT-1:0] out_state,
    output logic [PINS_COUNT-1:0] pin_state,
    output logic [PINS_COUNT-1:0] rise_evt,
    output logic [PINS_COUNT-1:0] fall_evt,
    input  logic [PINS_COUNT-1:0] irq_rise_en,
    input  logic [PINS_COUNT-1:0] irq_fall_en,
    input  logic [PINS_COUNT-1:0] irq_ack,
    output logic [PINS_COUNT-1:0] irq_pending,
    output logic                  irq
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [PINS_COUNT-1:0] out_q, out_d;
    logic [PINS_COUNT-1:0] sync_q [SYNC_STAGES];
    logic [PINS_COUNT-1:0] sync_in;
    logic [7:0]            cnt_q [PINS_COUNT];
    logic [7:0]            cnt_d [PINS_COUNT];
    logic [PINS_COUNT-1:0] pin_q, pin_d;
    logic [PINS_COUNT-1:0] prev_q;
    logic [PINS_COUNT-1:0] rise_q, fall_q;
    logic [PINS_COUNT-1:0] pend_q, pend_d;

    for (genvar g = 0; g < PINS_COUNT; g++) begin : g_pad
        assign io_pins[g] = dir[g] ? out_q[g] : 1'bz;
    end

    always_comb begin
        out_d = out_q;
        if (wr_en) begin
            unique case (wr_mode)
                2'b00:   out_d = wr_data;
                2'b01:   out_d = out_q | wr_data;
                2'b10:   out_d = out_q & ~wr_data;
                default: out_d = out_q ^ wr_data;
            endcase
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Counter holds cycles of disagreement seen so far; the last one flips state.
    always_comb begin
        pin_d = pin_q;
        for (int i = 0; i < PINS_COUNT; i++) begin
            cnt_d[i] = '0;
            if (sync_in[i] != pin_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    pin_d[i] = ~pin_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign pend_d = (pend_q & ~irq_ack)
                  | (rise_q & irq_rise_en)
                  | (fall_q & irq_fall_en);

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            out_q  <= '0;
            pin_q  <= '0;
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < PINS_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            sync_q[0] <= io_pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            for (int i = 0; i < PINS_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pin_q  <= pin_d;
            prev_q <= pin_q;
            rise_q <= pin_q & ~prev_q;
            fall_q <= ~pin_q & prev_q;
            pend_q <= pend_d;
        end
    end

    assign out_state   = out_q;
    assign pin_state   = pin_q;
    assign rise_evt    = rise_q;
    assign fall_evt    = fall_q;
    assign irq_pending = pend_q;
    assign irq         = |pend_q;

endmodule

// File: tb/tb_gpio_bank_fpga.sv
// Directed bench for gpio_bank_fpga at default parameters.
module tb_gpio_bank_fpga;

    logic        CLK50 = 1'b0;
    logic        RST_N;
    wire  [16:0] pins;
    logic [16:0] dir;
    logic [16:0] ext_val;
    logic        wr_en;
    logic [1:0]  wr_mode;
    logic [16:0] wr_data;
    logic [16:0] out_state, pin_state, rise_evt, fall_evt;
    logic [16:0] irq_rise_en, irq_fall_en, irq_ack, irq_pending;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 CLK50 = ~CLK50;

    for (genvar g = 0; g < 17; g++) begin : g_ext
        assign pins[g] = dir[g] ? 1'bz : ext_val[g];
    end

    gpio_bank_fpga dut (
        .CLK50      (CLK50),
        .RST_N      (RST_N),
        .io_pins    (pins),
        .dir        (dir),
        .wr_en      (wr_en),
        .wr_mode    (wr_mode),
        .wr_data    (wr_data),
        .out_state  (out_state),
        .pin_state  (pin_state),
        .rise_evt   (rise_evt),
        .fall_evt   (fall_evt),
        .irq_rise_en(irq_rise_en),
        .irq_fall_en(irq_fall_en),
        .irq_ack    (irq_ack),
        .irq_pending(irq_pending),
        .irq        (irq)
    );

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; dir = '0; ext_val = '0;
        wr_en = 1'b0; wr_mode = 2'b00; wr_data = '0;
        irq_rise_en = '0; irq_fall_en = '0; irq_ack = '0;
        #12;
        checks++;
        if (out_state !== 17'h0) begin
            failures++; $display("FAIL reset_out got=%h exp=0", out_state);
        end
        checks++;
        if (pin_state !== 17'h0) begin
            failures++; $display("FAIL reset_pin got=%h exp=0", pin_state);
        end
        checks++;
        if ((rise_evt | fall_evt) !== 17'h0) begin
            failures++;
            $display("FAIL reset_evt got=%h/%h exp=0", rise_evt, fall_evt);
        end
        checks++;
        if (irq_pending !== 17'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%h/%b exp=0/0", irq_pending, irq);
        end
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_write();
        logic [1:0]  modes [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [16:0] datas [4] = '{17'h1A5A5, 17'h00003, 17'h00021, 17'h10000};
        logic [16:0] exps  [4] = '{17'h1A5A5, 17'h1A5A7, 17'h1A586, 17'h0A586};
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_mode = modes[k]; wr_data = datas[k];
            tick();
            checks++;
            if (out_state !== exps[k]) begin
                failures++;
                $display("FAIL write_%0d got=%h exp=%h", k, out_state, exps[k]);
            end
        end
        wr_en = 1'b0; wr_mode = 2'b00; wr_data = 17'h1FFFF;
        tick(); tick();
        checks++;
        if (out_state !== 17'h0A586) begin
            failures++; $display("FAIL write_hold got=%h exp=0a586", out_state);
        end
    endtask

    task automatic test_tristate();
        wr_en = 1'b1; wr_mode = 2'b00; wr_data = 17'h00005;
        tick();
        wr_en = 1'b0;
        dir = 17'h0000F; ext_val = 17'h1FFFE;
        #1;
        checks++;
        if (pins !== 17'h1FFF5) begin
            failures++; $display("FAIL tri_drive got=%h exp=1fff5", pins);
        end
        dir = 17'h0000E;
        #1;
        checks++;
        if (pins !== 17'h1FFF4) begin
            failures++; $display("FAIL tri_release got=%h exp=1fff4", pins);
        end
        dir = '0; ext_val = '0;
        #1;
    endtask

    task automatic test_debounce();
        ext_val[2] = 1'b1;
        repeat (5) tick();
        checks++;
        if (pin_state !== 17'h0) begin
            failures++; $display("FAIL deb_early got=%h exp=0", pin_state);
        end
        tick();
        checks++;
        if (pin_state !== 17'h00004 || rise_evt !== 17'h0) begin
            failures++;
            $display("FAIL deb_edge6 got=%h/%h exp=4/0", pin_state, rise_evt);
        end
        tick();
        checks++;
        if (rise_evt !== 17'h00004 || fall_evt !== 17'h0) begin
            failures++;
            $display("FAIL deb_evt got=%h/%h exp=4/0", rise_evt, fall_evt);
        end
        tick();
        checks++;
        if (rise_evt !== 17'h0) begin
            failures++; $display("FAIL deb_pulse got=%h exp=0", rise_evt);
        end
    endtask

    task automatic test_glitch();
        logic [16:0] seen_evt = '0;
        logic        seen_pin = 1'b0;
        ext_val[5] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) ext_val[5] = 1'b0;
            tick();
            seen_evt |= rise_evt | fall_evt;
            seen_pin |= pin_state[5];
        end
        checks++;
        if (seen_pin !== 1'b0) begin
            failures++; $display("FAIL glitch_pin got=%b exp=0", seen_pin);
        end
        checks++;
        if (seen_evt !== 17'h0) begin
            failures++; $display("FAIL glitch_evt got=%h exp=0", seen_evt);
        end
    endtask

    task automatic wait_fall7(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fall_evt[7]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_irq();
        bit seen;
        irq_fall_en = 17'h00080;
        ext_val[7] = 1'b1;
        repeat (10) tick();
        checks++;
        if (irq_pending !== 17'h0) begin
            failures++; $display("FAIL irq_rise_masked got=%h exp=0", irq_pending);
        end
        ext_val[7] = 1'b0;
        wait_fall7(seen);
        checks++;
        if (!seen) begin
            failures++; $display("FAIL irq_fall1 got=timeout exp=fall_evt");
        end
        tick();
        checks++;
        if (irq_pending !== 17'h00080 || irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_set got=%h/%b exp=80/1", irq_pending, irq);
        end
        ext_val[7] = 1'b1;
        repeat (10) tick();
        ext_val[7] = 1'b0;
        wait_fall7(seen);
        checks++;
        if (!seen) begin
            failures++; $display("FAIL irq_fall2 got=timeout exp=fall_evt");
        end
        irq_ack = 17'h00080;
        tick();
        irq_ack = '0;
        checks++;
        if (irq_pending !== 17'h00080) begin
            failures++; $display("FAIL irq_set_wins got=%h exp=80", irq_pending);
        end
        irq_fall_en = '0;
        tick();
        checks++;
        if (irq_pending !== 17'h00080) begin
            failures++; $display("FAIL irq_en_off got=%h exp=80", irq_pending);
        end
        irq_ack = 17'h00080;
        tick();
        irq_ack = '0;
        checks++;
        if (irq_pending !== 17'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_ack got=%h/%b exp=0/0", irq_pending, irq);
        end
    endtask

    task automatic test_reset_mid();
        ext_val[9] = 1'b1;
        repeat (4) tick();
        RST_N = 1'b0;
        #1;
        checks++;
        if ((out_state | pin_state | rise_evt | fall_evt | irq_pending) !== 17'h0
            || irq !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outs got=%h/%h/%h/%h/%h exp=0", out_state,
                     pin_state, rise_evt, fall_evt, irq_pending);
        end
        tick(); tick();
        RST_N = 1'b1;
        repeat (5) tick();
        checks++;
        if (pin_state !== 17'h0) begin
            failures++; $display("FAIL rst_mid_early got=%h exp=0", pin_state);
        end
        tick();
        checks++;
        if (pin_state !== 17'h00204) begin
            failures++; $display("FAIL rst_mid_pin got=%h exp=00204", pin_state);
        end
        tick();
        checks++;
        if (rise_evt !== 17'h00204 || fall_evt !== 17'h0) begin
            failures++;
            $display("FAIL rst_mid_evt got=%h/%h exp=00204/0", rise_evt, fall_evt);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_tristate();
        test_debounce();
        test_glitch();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_bank_fpga.md
GPIO_BANK_FPGA -- requirements
Module: gpio_bank_fpga

Interface
REQ-001 The block SHALL have these parameters: PINS_COUNT, default 17, number of bidirectional pins.
REQ-002 SYNC_STAGES, default 2, input synchroniser depth (legal range 2..4).
REQ-003 DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before an input change is accepted (legal range 1..255).
REQ-004 Ports, in order:
- CLK50  in  1  sole clock, all flops on rising edge
- RST_N  in  1  asynchronous, active-low reset
- io_pins  inout  PINS_COUNT  physical pins
- dir  in  PINS_COUNT  per-pin direction, 1 = output, 0 = input
- wr_en  in  1  output-register write strobe
- wr_mode  in  2  00 load, 01 set, 10 clear, 11 toggle
- wr_data  in  PINS_COUNT  data/mask for the write
- out_state  out  PINS_COUNT  current output register
- pin_state  out  PINS_COUNT  debounced pin level
- rise_evt  out  PINS_COUNT  one-cycle pulse on accepted 0->1
- fall_evt  out  PINS_COUNT  one-cycle pulse on accepted 1->0
- irq_rise_en  in  PINS_COUNT  per-pin rising-edge interrupt enable
- irq_fall_en  in  PINS_COUNT  per-pin falling-edge interrupt enable
- irq_ack  in  PINS_COUNT  per-pin pending clear, write-1-to-clear
- irq_pending  out  PINS_COUNT  sticky per-pin interrupt flags
- irq  out  1  OR of irq_pending

Function
REQ-005 io_pins[i] SHALL be driven with out_state[i] when dir[i]=1 and SHALL be high-Z when dir[i]=0; this is combinational, and a change of dir takes effect in the same cycle.
REQ-006 The output register SHALL update on a CLK50 edge with wr_en=1, per wr_mode:
- load: out_state = wr_data
- set: out_state |= wr_data
- clear: out_state &= ~wr_data
- toggle: out_state ^= wr_data
REQ-007 With wr_en=0 the output register SHALL hold its value.
REQ-008 Each pin SHALL be sampled every cycle through a SYNC_STAGES flop chain regardless of dir, so output pins read back through the input path.
REQ-009 Debounce, per pin: a counter SHALL increment while the synchronised value differs from pin_state.
REQ-010 The debounce counter SHALL clear to 0 on any cycle where the synchronised value equals pin_state.
REQ-011 pin_state SHALL toggle on the edge where the difference has persisted for DEBOUNCE_CYCLES consecutive cycles; the counter SHALL clear on that same edge.
REQ-012 A clean pin step SHALL appear on pin_state exactly SYNC_STAGES+DEBOUNCE_CYCLES CLK50 edges after it is first sampled.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no pin_state change and no event.
REQ-014 rise_evt[i] / fall_evt[i] SHALL be registered and asserted for exactly one cycle, in the cycle following the pin_state[i] update.
REQ-015 irq_pending[i] SHALL set on (rise_evt[i] & irq_rise_en[i]) | (fall_evt[i] & irq_fall_en[i]).
REQ-016 irq_pending[i] SHALL clear on irq_ack[i]=1; if set and ack occur in the same cycle, set SHALL win.
REQ-017 Disabling an enable SHALL NOT clear an already-pending flag.
REQ-018 irq SHALL be the combinational OR of irq_pending.
REQ-019 The pins SHALL be independent: simultaneous events on any subset of pins SHALL all be captured in the same cycle.

Reset
REQ-020 RST_N low SHALL asynchronously clear out_state, all synchroniser flops, debounce counters, pin_state, rise_evt, fall_evt and irq_pending to 0; irq SHALL then be 0.
REQ-021 With RST_N low, pins whose dir=1 SHALL drive 0.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count.
REQ-023 After RST_N deasserts, the first functional edge SHALL be the next CLK50 rising edge.
REQ-024 A pin held high through reset SHALL produce one rise_evt once its debounce completes after reset.

Verification
REQ-025 Defaults; wr_mode=00 with 0x1A5A5, then 01 with 0x00003, then 10 with 0x00021, then 11 with 0x10000 -> out_state 0x1A5A5, 0x1A5A7, 0x1A586, 0x0A586.
REQ-026 dir=0x0000F, out_state=0x5 -> io_pins[3:0] = 0101 and pins 16..4 high-Z; flipping dir[0] to 0 -> pin 0 high-Z the same cycle.
REQ-027 An external pin 2 step 0->1 held steady -> pin_state[2] rises 6 edges after the first sample, rise_evt[2] is a single pulse one cycle later, and no other event bits assert.
REQ-028 A 3-cycle-wide high pulse on pin 5 -> pin_state[5] stays 0, and rise_evt and fall_evt stay 0.
REQ-029 irq_fall_en[7]=1 with a pin 7 fall -> irq_pending[7]=1 and irq=1; irq_ack[7] in the same cycle as a new fall_evt[7] -> pending stays 1; ack alone -> pending 0 and irq 0.
REQ-030 RST_N pulsed low 2 cycles into pin 9 debounce -> all outputs 0, and after release pin_state[9] follows a full 6-edge latency.
